// File: rtl/noc_vc_link_sender.sv
`default_nettype none
// ============================================================================
//  Module   : noc_vc_link_sender
//  Purpose  : Credit-based NoC link sender. It keeps one FIFO and one credit
//             counter per VC, and round-robin arbitrates onto a registered link.
//  Revision : 1.0  initial release
// ============================================================================
module noc_vc_link_sender #(
    parameter  int DATA_W     = 16,
    parameter  int NUM_VC     = 2,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CREDITS    = 4,
    localparam int VC_W       = $clog2(NUM_VC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              enable,
    output logic [DATA_W-1:0] data,
    output logic [VC_W-1:0]   vc,
    input  logic              credit,
    input  logic [VC_W-1:0]   credit_vc,
    output logic              err_credit
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CREDITS);

    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_elig;
    logic [NUM_VC-1:0] w_err_set;
    logic [DATA_W-1:0] w_head [NUM_VC];

    logic              w_gnt_valid;
    logic [VC_W-1:0]   w_gnt_vc;
    logic [VC_W-1:0]   w_idx;
    logic [VC_W-1:0]   r_rr;

    assign in_ready = ~w_full[in_vc];

    for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_vc
        logic [PTR_W:0]    r_wptr;
        logic [PTR_W:0]    r_rptr;
        logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
        logic [CNT_W-1:0]  r_cnt;
        logic              w_push;
        logic              w_pop;
        logic              w_cred;

        // Extra pointer MSB separates full from empty when the low bits match.
        assign w_full[gv]    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                               (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
        assign w_empty[gv]   = (r_wptr == r_rptr);
        assign w_head[gv]    = r_mem[r_rptr[PTR_W-1:0]];
        assign w_elig[gv]    = !w_empty[gv] && (r_cnt != '0);
        assign w_push        = in_valid && !w_full[gv] && (in_vc == VC_W'(gv));
        assign w_pop         = w_gnt_valid && (w_gnt_vc == VC_W'(gv));
        assign w_cred        = credit && (credit_vc == VC_W'(gv));
        assign w_err_set[gv] = w_cred && !w_pop && (r_cnt == c_CNT_MAX);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= in_data;
        end

        // A send and a credit on the same edge cancel out.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt <= c_CNT_MAX;
            end else if (w_cred && !w_pop && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_cred) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_vc    = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_VC; k++) begin
            w_idx = VC_W'((int'(r_rr) + k) % NUM_VC);
            if (!w_gnt_valid && w_elig[w_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_vc    = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr       <= VC_W'(NUM_VC - 1);
            enable     <= 1'b0;
            data       <= '0;
            vc         <= '0;
            err_credit <= 1'b0;
        end else begin
            enable     <= w_gnt_valid;
            err_credit <= err_credit | (|w_err_set);
            if (w_gnt_valid) begin
                r_rr <= w_gnt_vc;
                data <= w_head[w_gnt_vc];
                vc   <= w_gnt_vc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_link_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_vc_link_sender
//  Purpose  : Self-checking bench for noc_vc_link_sender; the reference model
//             is built from per-VC queues and integer credit counts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_noc_vc_link_sender;

    localparam int DATA_W     = 16;
    localparam int NUM_VC     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CREDITS    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [0:0]        in_vc = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              enable;
    logic [DATA_W-1:0] data;
    logic [0:0]        vc;
    logic              credit = 1'b0;
    logic [0:0]        credit_vc = '0;
    logic              err_credit;

    noc_vc_link_sender #(
        .DATA_W    (DATA_W),
        .NUM_VC    (NUM_VC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CREDITS   (CREDITS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_vc     (in_vc),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .enable    (enable),
        .data      (data),
        .vc        (vc),
        .credit    (credit),
        .credit_vc (credit_vc),
        .err_credit(err_credit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] mq [NUM_VC][$];
    int                mcnt [NUM_VC];
    int                mrr;
    logic              m_en;
    logic [DATA_W-1:0] m_data;
    int                m_vc;
    logic              m_err;
    int                sent [NUM_VC];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            mq[v].delete();
            mcnt[v] = CREDITS;
            sent[v] = 0;
        end
        mrr    = NUM_VC - 1;
        m_en   = 1'b0;
        m_data = '0;
        m_vc   = 0;
        m_err  = 1'b0;
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic step(output bit acc);
        int g;
        int c;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, mq[in_vc].size() < FIFO_DEPTH});
        acc = in_valid && (mq[in_vc].size() < FIFO_DEPTH);
        g = -1;
        for (int k = 1; k <= NUM_VC; k++) begin
            int i;
            i = (mrr + k) % NUM_VC;
            if (g < 0 && mq[i].size() > 0 && mcnt[i] > 0) g = i;
        end
        if (g >= 0) begin
            m_data = mq[g].pop_front();
            m_vc   = g;
            mrr    = g;
            mcnt[g]--;
        end
        m_en = (g >= 0);
        if (acc) mq[in_vc].push_back(in_data);
        if (credit) begin
            c = int'(credit_vc);
            if (g == c)                mcnt[c]++;
            else if (mcnt[c] == CREDITS) m_err = 1'b1;
            else                       mcnt[c]++;
        end
        @(posedge clk);
        #1;
        check("enable", {31'd0, enable}, {31'd0, m_en});
        check("data", {16'd0, data}, {16'd0, m_data});
        check("vc", {31'd0, vc}, 32'(m_vc));
        check("err_credit", {31'd0, err_credit}, {31'd0, m_err});
        if (enable) sent[vc]++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic push(input int v, input logic [DATA_W-1:0] d);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_vc    = 1'(v);
        in_data  = d;
        for (int t = 0; t < 20 && !done; t++) begin
            step(acc);
            done = acc;
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic give_credit(input int v);
        bit acc;
        credit    = 1'b1;
        credit_vc = 1'(v);
        step(acc);
        credit    = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, held with traffic offered.
    task automatic do_reset();
        rst      = 1'b0;
        credit   = 1'b0;
        #1;
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_data", {16'd0, data}, 32'd0);
        check("rst_err", {31'd0, err_credit}, 32'd0);
        model_reset();
        in_valid = 1'b1;
        in_vc    = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_ready", {31'd0, in_ready}, 32'd1);
            check("rst_hold_enable", {31'd0, enable}, 32'd0);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
    endtask

    initial begin
        bit acc;
        model_reset();
        do_reset();

        // Single flit latency
        push(0, 16'hA5A5);
        idle(1);
        check("t2_enable", {31'd0, enable}, 32'd1);
        check("t2_data", {16'd0, data}, 32'h0000A5A5);
        check("t2_vc", {31'd0, vc}, 32'd0);

        // Credit exhaustion on VC1
        do_reset();
        for (int i = 0; i < 6; i++) push(1, DATA_W'(16'h1100 + i));
        idle(4);
        check("t3_sent_before_credit", 32'(sent[1]), 32'd4);
        give_credit(1);
        idle(3);
        check("t3_sent_after_credit", 32'(sent[1]), 32'd5);

        // Backpressure on VC0 while VC1 keeps flowing
        do_reset();
        for (int i = 0; i < 8; i++) push(0, DATA_W'(16'h0500 + i));
        in_valid = 1'b1;
        in_vc    = 1'b0;
        #1;
        check("t5_ready_vc0", {31'd0, in_ready}, 32'd0);
        in_vc = 1'b1;
        #1;
        check("t5_ready_vc1", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        push(1, 16'hB001);
        push(1, 16'hB002);
        idle(3);
        check("t5_vc1_sent", 32'(sent[1]), 32'd2);
        check("t5_vc0_sent", 32'(sent[0]), 32'd4);

        // Same-edge send and credit on VC0: two credits must yield two sends
        give_credit(0);
        give_credit(0);
        idle(3);
        check("t6_same_edge_sent", 32'(sent[0]), 32'd6);

        // Credit overflow is sticky until reset
        do_reset();
        give_credit(1);
        idle(4);
        check("t6_err_sticky", {31'd0, err_credit}, 32'd1);
        do_reset();
        idle(1);
        check("t6_err_cleared", {31'd0, err_credit}, 32'd0);

        // Randomised traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int cv;
            if (cyc == 1500) do_reset();
            in_valid = ($urandom_range(0, 99) < 70);
            in_vc    = 1'($urandom_range(0, NUM_VC - 1));
            in_data  = DATA_W'($urandom);
            cv       = $urandom_range(0, NUM_VC - 1);
            credit_vc = 1'(cv);
            credit   = (mcnt[cv] < CREDITS && $urandom_range(0, 99) < 45) ||
                       ($urandom_range(0, 999) < 3);
            step(acc);
        end
        in_valid = 1'b0;
        credit   = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
